// File: rtl/rx_frame_fifo.sv
// rx_frame_fifo: store-and-forward RX frame buffer that only releases complete, error-free frames
module rx_frame_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  input  logic                  clear_counters,
  output logic [31:0]           frame_count,
  output logic [31:0]           drop_count,
  output logic [ADDR_WIDTH:0]   fifo_level
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int W = DATA_WIDTH + KEEP_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] FULL_LVL = {1'b1, {ADDR_WIDTH{1'b0}}};
  typedef enum logic {ST_WRITE, ST_DROP} state_t;
  state_t              r_state;
  logic [ADDR_WIDTH:0] r_wr_ptr, r_wr_commit, r_rd_ptr;
  logic                r_err, r_tready;
  logic [W-1:0]        r_mem [DEPTH];
  logic [W-1:0]        r_s1;
  logic                r_s1_valid, r_m_valid, r_m_last;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic [KEEP_WIDTH-1:0] r_m_keep;
  logic [31:0]         r_frame_count, r_drop_count;
  logic w_acc, w_full, w_bad, w_we, w_commit, w_drop, w_room, w_rd;
  assign w_acc    = s_axis_tvalid & r_tready;
  assign w_full   = (r_wr_ptr - r_rd_ptr) == FULL_LVL;
  assign w_bad    = r_err | s_axis_tuser;
  assign w_we     = w_acc & (r_state == ST_WRITE) & ~w_full & ~(s_axis_tlast & w_bad);
  assign w_commit = w_we & s_axis_tlast;
  assign w_drop   = w_acc & s_axis_tlast & ((r_state == ST_DROP) | w_full | w_bad);
  assign w_room   = ~r_m_valid | m_axis_tready;
  assign w_rd     = w_room & (r_rd_ptr != r_wr_commit);
  assign s_axis_tready = r_tready;
  assign m_axis_tdata  = r_m_data;
  assign m_axis_tkeep  = r_m_keep;
  assign m_axis_tlast  = r_m_last;
  assign m_axis_tvalid = r_m_valid;
  assign frame_count   = r_frame_count;
  assign drop_count    = r_drop_count;
  assign fifo_level    = r_wr_ptr - r_rd_ptr;
  // write FSM: store beats, commit good frames, rewind to the last commit point on error/overflow
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_WRITE;
      r_wr_ptr    <= '0;
      r_wr_commit <= '0;
      r_err       <= 1'b0;
      r_tready    <= 1'b0;
    end else begin
      r_tready <= 1'b1;
      if (w_acc) r_err <= ~s_axis_tlast & w_bad;
      if (w_acc && r_state == ST_DROP) begin
        if (s_axis_tlast) r_state <= ST_WRITE;
      end else if (w_acc && (w_full || (s_axis_tlast && w_bad))) begin
        r_wr_ptr <= r_wr_commit;
        if (!s_axis_tlast) r_state <= ST_DROP;
      end else if (w_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (s_axis_tlast) r_wr_commit <= r_wr_ptr + 1'b1;
      end
    end
  end
  // buffer RAM write port
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
  end
  // buffer RAM synchronous read port (first pipeline stage data)
  always_ff @(posedge clk) begin
    if (w_rd) r_s1 <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
  end
  // read pipeline: issue reads of committed beats while the output register can move
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_ptr   <= '0;
      r_s1_valid <= 1'b0;
      r_m_valid  <= 1'b0;
      r_m_last   <= 1'b0;
      r_m_keep   <= '0;
      r_m_data   <= '0;
    end else begin
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_room) begin
        r_s1_valid <= w_rd;
        r_m_valid  <= r_s1_valid;
        if (r_s1_valid) {r_m_last, r_m_keep, r_m_data} <= r_s1;
      end
    end
  end
  // statistics counters, clear wins over a coincident event
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_frame_count <= '0;
      r_drop_count  <= '0;
    end else begin
      r_frame_count <= clear_counters ? '0 : r_frame_count + 32'(w_commit);
      r_drop_count  <= clear_counters ? '0 : r_drop_count + 32'(w_drop);
    end
  end
endmodule

// File: tb/tb_rx_frame_fifo.sv
// tb_rx_frame_fifo: scoreboard bench for rx_frame_fifo with a frame-level reference model
module tb_rx_frame_fifo;
  localparam int DW = 64, KW = 8, AW = 4, DEPTH = 16;
  logic clk = 0, rstn = 0;
  logic [DW-1:0] s_data = '0, m_data;
  logic [KW-1:0] s_keep = '0, m_keep;
  logic s_valid = 0, s_ready, s_last = 0, s_user = 0;
  logic m_valid, m_ready, m_last, clear = 0;
  logic [31:0] frame_count, drop_count;
  logic [AW:0] fifo_level;
  int checks = 0, passes = 0;
  int exp_frames = 0, exp_drops = 0;
  int rdy_mode = 0, rdy_idx = 0;
  logic [72:0] exp_q[$];

  always #5 clk = ~clk;

  rx_frame_fifo #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tvalid(s_valid),
    .s_axis_tready(s_ready), .s_axis_tlast(s_last), .s_axis_tuser(s_user),
    .m_axis_tdata(m_data), .m_axis_tkeep(m_keep), .m_axis_tvalid(m_valid),
    .m_axis_tready(m_ready), .m_axis_tlast(m_last),
    .clear_counters(clear), .frame_count(frame_count), .drop_count(drop_count),
    .fifo_level(fifo_level)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // downstream ready patterns: 0 always, 1 never, 2 repeating 1,0,0,1, 3 random
  initial begin
    m_ready = 0;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'b0 :
                rdy_mode == 2 ? (rdy_idx % 4 == 0 || rdy_idx % 4 == 3) : 1'($urandom_range(0, 1));
      rdy_idx++;
    end
  end

  // monitor: hold-stability while stalled, and in-order compare of every transferred beat
  initial begin
    logic prev_stall;
    logic [72:0] prev_out, e;
    prev_stall = 0;
    prev_out = '0;
    forever begin
      @(negedge clk);
      if (!rstn) prev_stall = 0;
      else begin
        if (prev_stall) chk("hold", {m_valid, m_last, m_keep, m_data}, {1'b1, prev_out});
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_beat: got %0h expected none", {m_last, m_keep, m_data});
          end else begin
            e = exp_q.pop_front();
            chk("beat", {m_last, m_keep, m_data}, e);
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_out = {m_last, m_keep, m_data};
      end
    end
  end

  // drive one frame; the model commits it only if it is error-free and fits the buffer
  task automatic send_frame(input int len, input int err_beat, input bit force_drop,
                            input bit clr_last, input int gap_pct);
    logic [72:0] beats[$];
    bit good;
    good = (err_beat < 0) && !force_drop && (len <= DEPTH);
    for (int i = 0; i < len; i++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        s_valid = 0;
        tick();
      end
      s_valid = 1;
      s_data = {$urandom, $urandom};
      s_keep = KW'($urandom_range(0, 255));
      s_last = (i == len - 1);
      s_user = (i == err_beat);
      clear = clr_last && s_last;
      beats.push_back({s_last, s_keep, s_data});
      if (s_last) begin
        if (good) foreach (beats[j]) exp_q.push_back(beats[j]);
        if (clr_last) begin
          exp_frames = 0;
          exp_drops = 0;
        end else if (good) exp_frames++;
        else exp_drops++;
      end
      tick();
    end
    s_valid = 0;
    s_last = 0;
    s_user = 0;
    clear = 0;
  endtask

  task automatic pulse_clear();
    clear = 1;
    tick();
    clear = 0;
    exp_frames = 0;
    exp_drops = 0;
  endtask

  task automatic wait_space(input int len);
    int n = 0;
    while (exp_q.size() + len > DEPTH && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) begin
      checks++;
      $display("FAIL space_timeout: got %0d queued expected <= %0d", exp_q.size(), DEPTH - len);
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    repeat (4) tick();
    chk({tag, "_drained"}, exp_q.size(), 0);
    chk({tag, "_level"}, fifo_level, 0);
    chk({tag, "_idle"}, m_valid, 0);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_frame_count"}, frame_count, exp_frames);
    chk({tag, "_drop_count"}, drop_count, exp_drops);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk("rst_tready", s_ready, 0);
    chk("rst_tvalid", m_valid, 0);
    chk("rst_tdata", m_data, 0);
    chk("rst_tkeep", m_keep, 0);
    chk("rst_tlast", m_last, 0);
    chk("rst_level", fifo_level, 0);
    chk_counts("rst");
    rstn = 1;
    repeat (2) tick();
    chk("tready_up", s_ready, 1);
    // single good frame, commit latency of two edges
    send_frame(8, -1, 0, 0, 0);
    chk("lat_n0", m_valid, 0);
    tick();
    chk("lat_n1", m_valid, 0);
    tick();
    chk("lat_n2", m_valid, 1);
    drain("good");
    chk_counts("good");
    // errored frame followed by a good one
    pulse_clear();
    send_frame(6, 2, 0, 0, 0);
    send_frame(4, -1, 0, 0, 0);
    drain("bad");
    chk_counts("bad");
    // overflow with a stalled parser: two beats of frame 1 already sit in the read pipeline
    pulse_clear();
    rdy_mode = 1;
    repeat (3) tick();
    send_frame(10, -1, 0, 0, 0);
    send_frame(10, -1, 1, 0, 0);
    chk_counts("ovf");
    chk("ovf_level", fifo_level, 8);
    rdy_mode = 0;
    drain("ovf");
    send_frame(DEPTH + 2, -1, 0, 0, 0);
    drain("long");
    chk_counts("long");
    // back-pressure with ready toggling 1,0,0,1
    pulse_clear();
    rdy_mode = 2;
    repeat (3) send_frame(5, -1, 0, 0, 0);
    drain("bp");
    chk_counts("bp");
    // clear coincident with a good tlast
    rdy_mode = 0;
    pulse_clear();
    send_frame(3, -1, 0, 0, 0);
    chk("pre_clear_frames", frame_count, 1);
    send_frame(4, -1, 0, 1, 0);
    chk("clear_wins", frame_count, 0);
    send_frame(2, -1, 0, 0, 0);
    chk("after_clear", frame_count, 1);
    drain("clr");
    chk_counts("clr");
    // randomized traffic with random errors, gaps and back-pressure
    pulse_clear();
    rdy_mode = 3;
    for (int f = 0; f < 40; f++) begin
      int len, eb;
      len = $urandom_range(1, 8);
      eb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      wait_space(len);
      send_frame(len, eb, 0, 0, 30);
    end
    drain("rand");
    chk_counts("rand");
    // reset mid-frame with a committed frame still buffered
    rdy_mode = 1;
    repeat (3) tick();
    send_frame(4, -1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      s_valid = 1;
      s_data = {$urandom, $urandom};
      tick();
    end
    s_data = {$urandom, $urandom};
    rstn = 0;
    exp_q.delete();
    exp_frames = 0;
    exp_drops = 0;
    tick();
    s_valid = 0;
    tick();
    chk("mid_rst_tready", s_ready, 0);
    chk("mid_rst_tvalid", m_valid, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk_counts("mid_rst");
    rstn = 1;
    rdy_mode = 0;
    repeat (3) tick();
    send_frame(3, -1, 0, 0, 0);
    drain("post_rst");
    chk_counts("post_rst");
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
